pipe_rca_param: RTL and testbench

//  Parametrised, bit-sliced pipelined ripple-carry adder/subtractor; next-gen 4-bit pipe_rca4.

---
 rtl/pipe_rca_param_pkg.sv | 23 ++
 rtl/pipe_rca_param_slice.sv | 31 +++
 rtl/pipe_rca_param.sv | 111 +++++++++++
 tb/tb_pipe_rca_param.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_rca_param_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: stage/latency math,
// parameter legality check and the one-bit full adder the slices are built from.
package pipe_rca_param_pkg;

    function automatic int calc_stages(input int width, input int bps);
        return width / bps;
    endfunction

    // Capture stage, one stage per slice, then the output register.
    function automatic int calc_latency(input int width, input int bps);
        return width / bps + 1;
    endfunction

    function automatic bit params_ok(input int width, input int bps);
        return (width >= 1) && (bps >= 1) && ((width % bps) == 0);
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] fulladder(input logic a, input logic b, input logic c);
        return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/pipe_rca_param_slice.sv
// BPS-bit combinational ripple-carry slice built from chained full adders.
// Latency: none (purely combinational).
// Backpressure: none; the enclosing pipeline decides when results are registered.
module pipe_rca_param_slice
    import pipe_rca_param_pkg::*;
#(
    parameter int BPS = 2
) (
    input  logic [BPS-1:0] a,
    input  logic [BPS-1:0] b,
    input  logic           cin,
    output logic [BPS-1:0] s,
    output logic           cout,
    output logic           c_msb_in
);

    logic [BPS:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < BPS; i++) begin
            {c[i+1], s[i]} = fulladder(a[i], b[i], c[i]);
        end
    end

    assign cout     = c[BPS];
    assign c_msb_in = c[BPS-1];

endmodule

// File: rtl/pipe_rca_param.sv
// Bit-sliced pipelined ripple-carry adder/subtractor with carry-out and signed overflow.
// Latency: WIDTH/BPS + 1 cycles from acceptance edge to out_valid; one beat per cycle.
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
module pipe_rca_param
    import pipe_rca_param_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPS   = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int STAGES  = calc_stages(WIDTH, BPS);
    localparam int LATENCY = calc_latency(WIDTH, BPS);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({BPS{1'b1}});

    if (!params_ok(WIDTH, BPS) || (LATENCY != STAGES + 1)) begin : g_param_err
        $error("pipe_rca_param: WIDTH must be >= 1 and a multiple of BPS");
    end

    logic             adv;
    // Operand skew chain: stage k still carries the bits slice k will consume.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    // Sum deskew chain: stage k holds the low k*BPS finished bits.
    logic [WIDTH-1:0] s_q   [1:STAGES];
    logic             c_q   [STAGES+1];
    logic             v_q   [STAGES+1];
    logic [BPS-1:0]   sl_s  [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic [STAGES-1:0] sl_c;
    logic [STAGES-1:0] sl_m;
    logic             m_q;
    logic             unused_m;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;
    assign unused_m = ^sl_m;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipe_rca_param_slice #(.BPS(BPS)) u_slice (
            .a        (a_q[k][k*BPS +: BPS]),
            .b        (b_q[k][k*BPS +: BPS]),
            .cin      (c_q[k]),
            .s        (sl_s[k]),
            .cout     (sl_c[k]),
            .c_msb_in (sl_m[k])
        );

        if (k == 0) begin : g_first
            assign s_nxt[k] = WIDTH'(sl_s[k]);
        end else begin : g_rest
            assign s_nxt[k] = (s_q[k] & ~(SLICE_MASK << (k*BPS)))
                            | (WIDTH'(sl_s[k]) << (k*BPS));
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 1; k <= STAGES; k++) begin
                s_q[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            m_q       <= 1'b0;
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
        end else if (adv) begin
            // Subtract is A + ~B + 1, so the inversion and forced carry happen at capture.
            a_q[0] <= A;
            b_q[0] <= B ^ {WIDTH{Sub}};
            c_q[0] <= Sub | Cin;
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                c_q[k+1] <= sl_c[k];
                v_q[k+1] <= v_q[k];
                s_q[k+1] <= s_nxt[k];
            end
            m_q       <= sl_m[STAGES-1];
            out_valid <= v_q[STAGES];
            Sum       <= s_q[STAGES];
            Cout      <= c_q[STAGES];
            Ovf       <= m_q ^ c_q[STAGES];
        end
    end

endmodule

// File: tb/tb_pipe_rca_param.sv
// Directed checks of the 8-bit/2-bit-slice adder plus random sweeps of 4/1 and 16/4 builds.
module tb_pipe_rca_param;
    import pipe_rca_param_pkg::*;

    localparam int LAT = calc_latency(8, 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic       iv, ir, cin, sub, ov, ordy, cout, ovf;
    logic [7:0] a, b, sum;

    logic        iv4, ir4, cin4, sub4, ov4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;
    logic        iv16, ir16, cin16, sub16, ov16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        ordy_s;

    logic [5:0]  q4  [$];
    logic [17:0] q16 [$];

    pipe_rca_param #(.WIDTH(8), .BPS(2)) dut (
        .Clk(clk), .Rst_n(rst_n), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
        .Cin(cin), .Sub(sub), .out_valid(ov), .out_ready(ordy), .Sum(sum),
        .Cout(cout), .Ovf(ovf)
    );

    pipe_rca_param #(.WIDTH(4), .BPS(1)) dut4 (
        .Clk(clk), .Rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .Cin(cin4), .Sub(sub4), .out_valid(ov4), .out_ready(ordy_s), .Sum(sum4),
        .Cout(cout4), .Ovf(ovf4)
    );

    pipe_rca_param #(.WIDTH(16), .BPS(4)) dut16 (
        .Clk(clk), .Rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .Cin(cin16), .Sub(sub16), .out_valid(ov16), .out_ready(ordy_s), .Sum(sum16),
        .Cout(cout16), .Ovf(ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {valid, ovf, cout, sum}.
    task automatic chk_out(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        chk(tag, {21'b0, ov, ovf, cout, sum}, {21'b0, 1'b1, eo, ec, es});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic vs);
        iv = 1'b1; a = va; b = vb; cin = vc; sub = vs;
    endtask

    task automatic idle;
        iv = 1'b0; a = 8'h5A; b = 8'hC3; cin = 1'b1; sub = 1'b0;
    endtask

    // n beats were just accepted on consecutive edges; advance to the first result.
    task automatic flush_wait(input int n, input string tag);
        for (int i = 0; i < LAT - n; i++) begin
            tick;
            chk(tag, 32'(ov), 0);
        end
        tick;
    endtask

    logic [7:0] ta [5] = '{8'd128, 8'd20, 8'd100, 8'd250, 8'd1};
    logic [7:0] tb [5] = '{8'd128, 8'd30, 8'd40,  8'd10,  8'd2};
    logic       ts [5] = '{1'b0,   1'b0,  1'b1,   1'b0,   1'b0};
    logic [7:0] es [5] = '{8'd0,   8'd50, 8'd60,  8'd4,   8'd3};
    logic       ec [5] = '{1'b1,   1'b0,  1'b1,   1'b1,   1'b0};
    logic       eo [5] = '{1'b1,   1'b0,  1'b0,   1'b0,   1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  r4;
        logic [3:0]  bb4;
        logic [16:0] r16;
        logic [15:0] bb16;
        logic [5:0]  e4;
        logic [17:0] e16;

        rst_n = 1'b0; ordy = 1'b1; ordy_s = 1'b1;
        idle;
        iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;

        #12;
        chk("rst_vld", 32'(ov), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_flags", {30'b0, cout, ovf}, 0);
        chk("rst_rdy", 32'(ir), 1);
        #10 rst_n = 1'b1;
        tick;

        // single add, exact latency
        drive(8'd7, 8'd5, 1'b0, 1'b0);
        tick;
        idle;
        flush_wait(1, "t1_early_vld");
        chk_out("t1_7p5", 8'd12, 1'b0, 1'b0);

        // streaming add then subtract
        drive(8'd200, 8'd100, 1'b1, 1'b0);
        tick;
        drive(8'd10, 8'd3, 1'b0, 1'b1);
        tick;
        idle;
        flush_wait(2, "t2_early_vld");
        chk_out("t2_200p100c", 8'd45, 1'b1, 1'b0);
        tick;
        chk_out("t2_10m3", 8'd7, 1'b1, 1'b0);
        tick;
        chk("t2_end_vld", 32'(ov), 0);

        // boundaries
        drive(8'd127, 8'd1, 1'b0, 1'b0);
        tick;
        drive(8'd0, 8'd1, 1'b1, 1'b1);
        tick;
        drive(8'd255, 8'd0, 1'b1, 1'b0);
        tick;
        idle;
        flush_wait(3, "t3_early_vld");
        chk_out("t3_127p1", 8'd128, 1'b0, 1'b1);
        tick;
        chk_out("t3_0m1", 8'd255, 1'b0, 1'b0);
        tick;
        chk_out("t3_255p0c", 8'd0, 1'b1, 1'b0);
        tick;
        chk("t3_end_vld", 32'(ov), 0);

        // back-pressure with five beats in flight
        for (int k = 0; k < 5; k++) begin
            drive(ta[k], tb[k], 1'b0, ts[k]);
            tick;
        end
        idle;
        ordy = 1'b0;
        tick;
        chk_out("t4_b0", es[0], ec[0], eo[0]);
        chk("t4_rdy_low", 32'(ir), 0);
        drive(8'd99, 8'd99, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out($sformatf("t4_hold%0d", i), es[0], ec[0], eo[0]);
            chk($sformatf("t4_hold_rdy%0d", i), 32'(ir), 0);
        end
        idle;
        ordy = 1'b1;
        #1;
        chk("t4_rel_rdy", 32'(ir), 1);
        for (int k = 1; k < 5; k++) begin
            tick;
            chk_out($sformatf("t4_b%0d", k), es[k], ec[k], eo[k]);
        end
        tick;
        chk("t4_no_dup", 32'(ov), 0);

        // reset with beats in flight
        for (int k = 0; k < 6; k++) begin
            drive(8'(10 + k), 8'(k), 1'b0, 1'b0);
            tick;
        end
        chk_out("t5_pre", 8'd10, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        idle;
        #1;
        chk("t5_rst_vld", 32'(ov), 0);
        chk("t5_rst_sum", 32'(sum), 0);
        chk("t5_rst_flags", {30'b0, cout, ovf}, 0);
        tick;
        tick;
        #2 rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick;
            chk($sformatf("t5_stale%0d", i), 32'(ov), 0);
        end
        drive(8'd9, 8'd9, 1'b0, 1'b0);
        tick;
        idle;
        flush_wait(1, "t5_post_early");
        chk_out("t5_post", 8'd18, 1'b0, 1'b0);
        tick;

        // random sweep of the 4/1 and 16/4 builds against a golden model
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc < 64 && $urandom_range(0, 3) != 0) begin
                iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
                cin4 = 1'($urandom); sub4 = 1'($urandom);
                bb4 = sub4 ? ~b4 : b4;
                r4  = {1'b0, a4} + {1'b0, bb4} + {4'b0, sub4 | cin4};
                q4.push_back({(a4[3] == bb4[3]) && (r4[3] != a4[3]), r4[4], r4[3:0]});
            end else begin
                iv4 = 1'b0;
            end
            if (cyc < 64 && $urandom_range(0, 3) != 0) begin
                iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
                cin16 = 1'($urandom); sub16 = 1'($urandom);
                bb16 = sub16 ? ~b16 : b16;
                r16  = {1'b0, a16} + {1'b0, bb16} + {16'b0, sub16 | cin16};
                q16.push_back({(a16[15] == bb16[15]) && (r16[15] != a16[15]), r16[16], r16[15:0]});
            end else begin
                iv16 = 1'b0;
            end
            chk("sw4_rdy", 32'(ir4), 1);
            chk("sw16_rdy", 32'(ir16), 1);
            tick;
            if (ov4) begin
                chk("sw4_unexpected", 32'(q4.size() != 0), 1);
                if (q4.size() != 0) begin
                    e4 = q4.pop_front();
                    chk($sformatf("sw4_c%0d", cyc), {26'b0, ovf4, cout4, sum4}, {26'b0, e4});
                end
            end
            if (ov16) begin
                chk("sw16_unexpected", 32'(q16.size() != 0), 1);
                if (q16.size() != 0) begin
                    e16 = q16.pop_front();
                    chk($sformatf("sw16_c%0d", cyc), {14'b0, ovf16, cout16, sum16}, {14'b0, e16});
                end
            end
        end
        chk("sw4_drain", 32'(q4.size()), 0);
        chk("sw16_drain", 32'(q16.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
